// File: rtl/mmu_pt_writer_if.sv
// rtl/mmu_pt_writer_if.sv - command, status and page-table port bundle for mmu_pt_writer
// Readback signals (pt_raddr, pt_rdata, rd_data) exist only when MMU_PT_READBACK_EN is defined.
interface mmu_pt_writer_if #(
   parameter int PT_AW   = 12,
   parameter int ENTRY_W = 8,
   parameter int PAGE_W  = 5
);
   logic               cmd_valid;
   logic               cmd_ready;
   logic [1:0]         cmd_op;
   logic [PT_AW-1:0]   cmd_ptb;
   logic [PAGE_W-1:0]  cmd_page;
   logic [ENTRY_W-1:0] cmd_data;
   logic               busy;
   logic               done;
   logic               err;
   logic               pt_we;
   logic [PT_AW-1:0]   pt_waddr;
   logic [ENTRY_W-1:0] pt_wdata;
`ifdef MMU_PT_READBACK_EN
   logic [PT_AW-1:0]   pt_raddr;
   logic [ENTRY_W-1:0] pt_rdata;
   logic [ENTRY_W-1:0] rd_data;

   modport master (
      output cmd_valid, cmd_op, cmd_ptb, cmd_page, cmd_data, pt_rdata,
      input  cmd_ready, busy, done, err, pt_we, pt_waddr, pt_wdata, pt_raddr, rd_data
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_ptb, cmd_page, cmd_data, pt_rdata,
      output cmd_ready, busy, done, err, pt_we, pt_waddr, pt_wdata, pt_raddr, rd_data
   );
`else
   modport master (
      output cmd_valid, cmd_op, cmd_ptb, cmd_page, cmd_data,
      input  cmd_ready, busy, done, err, pt_we, pt_waddr, pt_wdata
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_ptb, cmd_page, cmd_data,
      output cmd_ready, busy, done, err, pt_we, pt_waddr, pt_wdata
   );
`endif
endinterface

// File: rtl/mmu_pt_writer.sv
// rtl/mmu_pt_writer.sv - write-side controller for the MMU page table RAM (single write, process fill, clear)
// Optional readback op (11) is built when MMU_PT_READBACK_EN is defined; otherwise op 11 pulses err.
module mmu_pt_writer #(
   parameter int PT_AW      = 12,
   parameter int ENTRY_W    = 8,
   parameter int PROC_PAGES = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   mmu_pt_writer_if.slave  bus
);

   localparam int CNT_W = $clog2(PROC_PAGES);

   localparam logic [1:0] OP_WRITE = 2'b00;
   localparam logic [1:0] OP_FILL  = 2'b01;
   localparam logic [1:0] OP_CLEAR = 2'b10;

   localparam logic [CNT_W-1:0]   FILL_LAST   = CNT_W'(PROC_PAGES - 1);
   localparam logic [CNT_W-1:0]   FILL_PENULT = CNT_W'(PROC_PAGES - 2);
   localparam logic [PT_AW-1:0]   ADDR_LAST   = {PT_AW{1'b1}};
   localparam logic [PT_AW-1:0]   ADDR_PENULT = {{(PT_AW-1){1'b1}}, 1'b0};
   localparam logic [PT_AW-1:0]   ADDR_ONE    = {{(PT_AW-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0]   CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [ENTRY_W-2:0] PAGE_ONE    = {{(ENTRY_W-2){1'b0}}, 1'b1};

   typedef enum logic [2:0] {
      S_IDLE,
      S_WRITE,
      S_FILL,
      S_CLEAR,
      S_READ_ADDR,
      S_READ_WAIT,
      S_READ_DONE
   } state_t;

   state_t             r_state;
   state_t             w_state;
   logic [CNT_W-1:0]   r_cnt;
   logic [CNT_W-1:0]   w_cnt;
   logic               r_pt_we;
   logic               w_pt_we;
   logic [PT_AW-1:0]   r_pt_waddr;
   logic [PT_AW-1:0]   w_pt_waddr;
   logic [ENTRY_W-1:0] r_pt_wdata;
   logic [ENTRY_W-1:0] w_pt_wdata;
   logic               r_done;
   logic               w_done;
   logic               r_err;
   logic               w_err;
   logic [PT_AW-1:0]   w_entry_addr;
   logic               w_idle;
`ifdef MMU_PT_READBACK_EN
   logic [PT_AW-1:0]   r_pt_raddr;
   logic [PT_AW-1:0]   w_pt_raddr;
   logic [ENTRY_W-1:0] r_rd_data;
   logic [ENTRY_W-1:0] w_rd_data;
`endif

   // Entry address of ptb+page; the carry out of the 12-bit add is dropped so it wraps to 0.
   assign w_entry_addr = bus.cmd_ptb + {{(PT_AW-$bits(bus.cmd_page)){1'b0}}, bus.cmd_page};

   // Handshake status decodes straight from state so a command is only taken in IDLE.
   assign w_idle        = (r_state == S_IDLE);
   assign bus.cmd_ready = w_idle;
   assign bus.busy      = ~w_idle;
   assign bus.pt_we     = r_pt_we;
   assign bus.pt_waddr  = r_pt_waddr;
   assign bus.pt_wdata  = r_pt_wdata;
   assign bus.done      = r_done;
   assign bus.err       = r_err;
`ifdef MMU_PT_READBACK_EN
   assign bus.pt_raddr  = r_pt_raddr;
   assign bus.rd_data   = r_rd_data;
`endif

   // Next-state and next-output decode; every output is computed one cycle ahead and registered.
   always_comb begin
      w_state    = r_state;
      w_cnt      = r_cnt;
      w_pt_we    = 1'b0;
      w_pt_waddr = r_pt_waddr;
      w_pt_wdata = r_pt_wdata;
      w_done     = 1'b0;
      w_err      = 1'b0;
`ifdef MMU_PT_READBACK_EN
      w_pt_raddr = r_pt_raddr;
      w_rd_data  = r_rd_data;
`endif
      case (r_state)
         S_IDLE: begin
            if (bus.cmd_valid) begin
               case (bus.cmd_op)
                  OP_WRITE: begin
                     w_state    = S_WRITE;
                     w_pt_we    = 1'b1;
                     w_pt_waddr = w_entry_addr;
                     w_pt_wdata = bus.cmd_data;
                     w_done     = 1'b1;
                  end
                  OP_FILL: begin
                     // First entry of the block: page index 0, first physical page, present set.
                     w_state    = S_FILL;
                     w_cnt      = '0;
                     w_pt_we    = 1'b1;
                     w_pt_waddr = bus.cmd_ptb;
                     w_pt_wdata = {1'b1, bus.cmd_data[ENTRY_W-2:0]};
                  end
                  OP_CLEAR: begin
                     w_state    = S_CLEAR;
                     w_pt_we    = 1'b1;
                     w_pt_waddr = '0;
                     w_pt_wdata = '0;
                  end
                  default: begin
`ifdef MMU_PT_READBACK_EN
                     w_state    = S_READ_ADDR;
                     w_pt_raddr = w_entry_addr;
`else
                     w_err      = 1'b1;
`endif
                  end
               endcase
            end
         end
         S_WRITE: begin
            w_state = S_IDLE;
         end
         S_FILL: begin
            if (r_cnt == FILL_LAST) begin
               w_state = S_IDLE;
            end else begin
               // Address and physical page both step by one; the page wraps within 7 bits.
               w_cnt      = r_cnt + CNT_ONE;
               w_pt_we    = 1'b1;
               w_pt_waddr = r_pt_waddr + ADDR_ONE;
               w_pt_wdata = {1'b1, r_pt_wdata[ENTRY_W-2:0] + PAGE_ONE};
               w_done     = (r_cnt == FILL_PENULT);
            end
         end
         S_CLEAR: begin
            // The address register doubles as the sweep counter; stop on 4095 before it wraps.
            if (r_pt_waddr == ADDR_LAST) begin
               w_state = S_IDLE;
            end else begin
               w_pt_we    = 1'b1;
               w_pt_waddr = r_pt_waddr + ADDR_ONE;
               w_pt_wdata = '0;
               w_done     = (r_pt_waddr == ADDR_PENULT);
            end
         end
`ifdef MMU_PT_READBACK_EN
         S_READ_ADDR: begin
            w_state = S_READ_WAIT;
         end
         S_READ_WAIT: begin
            // RAM data for pt_raddr is valid this cycle; capture it and flag completion.
            w_state   = S_READ_DONE;
            w_rd_data = bus.pt_rdata;
            w_done    = 1'b1;
         end
         S_READ_DONE: begin
            w_state = S_IDLE;
         end
`endif
         default: begin
            w_state = S_IDLE;
         end
      endcase
   end

   // State and registered outputs; async reset drops pt_we immediately, even mid-sweep.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_pt_we    <= 1'b0;
         r_pt_waddr <= '0;
         r_pt_wdata <= '0;
         r_done     <= 1'b0;
         r_err      <= 1'b0;
`ifdef MMU_PT_READBACK_EN
         r_pt_raddr <= '0;
         r_rd_data  <= '0;
`endif
      end else begin
         r_state    <= w_state;
         r_cnt      <= w_cnt;
         r_pt_we    <= w_pt_we;
         r_pt_waddr <= w_pt_waddr;
         r_pt_wdata <= w_pt_wdata;
         r_done     <= w_done;
         r_err      <= w_err;
`ifdef MMU_PT_READBACK_EN
         r_pt_raddr <= w_pt_raddr;
         r_rd_data  <= w_rd_data;
`endif
      end
   end

endmodule

// File: tb/tb_mmu_pt_writer.sv
// tb/tb_mmu_pt_writer.sv - randomized self-checking bench for mmu_pt_writer (MMU_PT_READBACK_EN selects the readback build)
module tb_mmu_pt_writer;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   mmu_pt_writer_if bus ();

   mmu_pt_writer dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

`ifdef MMU_PT_READBACK_EN
   localparam bit RB = 1'b1;
`else
   localparam bit RB = 1'b0;
`endif

   typedef struct packed {
      logic        we;
      logic [11:0] addr;
      logic [7:0]  data;
      logic        done;
      logic        err;
      logic        busy;
      logic        chk_rd;
      logic [7:0]  rd;
   } exp_t;

   exp_t        q[$];
   logic [7:0]  shadow [4096];
   int          n_tests = 0;
   int          n_fail  = 0;
   int          n_writes = 0;
   int          n_busy  = 0;
   int          n_done  = 0;
   int          n_err   = 0;
   logic [11:0] last_addr = '0;
   logic [7:0]  last_data = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [11:0] f_addr(input int base, input int off);
      return 12'((base + off) % 4096);
   endfunction

   function automatic logic [7:0] f_fill(input int first, input int i);
      return 8'(128 + ((first % 128) + i) % 128);
   endfunction

   function automatic exp_t mk(input logic we, input logic [11:0] a, input logic [7:0] d,
                               input logic dn, input logic er, input logic bz,
                               input logic cr, input logic [7:0] rd);
      exp_t e;
      e.we = we; e.addr = a; e.data = d; e.done = dn; e.err = er;
      e.busy = bz; e.chk_rd = cr; e.rd = rd;
      return e;
   endfunction

   // Spec-level model: every accepted command becomes its list of per-cycle expectations.
   task automatic model_cmd(input logic [1:0] op, input logic [11:0] ptb, input logic [4:0] page,
                            input logic [7:0] data);
      case (op)
         2'b00: q.push_back(mk(1'b1, f_addr(int'(ptb), int'(page)), data, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00));
         2'b01: for (int i = 0; i < 32; i++)
                   q.push_back(mk(1'b1, f_addr(int'(ptb), i), f_fill(int'(data), i), (i == 31), 1'b0, 1'b1, 1'b0, 8'h00));
         2'b10: for (int i = 0; i < 4096; i++)
                   q.push_back(mk(1'b1, 12'(i), 8'h00, (i == 4095), 1'b0, 1'b1, 1'b0, 8'h00));
         default: begin
            if (RB) begin
               q.push_back(mk(1'b0, 12'h000, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00));
               q.push_back(mk(1'b0, 12'h000, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00));
               q.push_back(mk(1'b0, 12'h000, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, shadow[f_addr(int'(ptb), int'(page))]));
            end else begin
               q.push_back(mk(1'b0, 12'h000, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00));
            end
         end
      endcase
   endtask

`ifdef MMU_PT_READBACK_EN
   logic [7:0] ram [4096];
   initial for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
   always @(posedge clk) begin
      if (bus.pt_we) ram[bus.pt_waddr] <= bus.pt_wdata;
      bus.pt_rdata <= ram[bus.pt_raddr];
   end
`endif

   // Compare process: one expectation per cycle while a command is active, idle values otherwise.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n) begin
         if (q.size() > 0) e = q.pop_front();
         else e = '0;
         chk("pt_we", bus.pt_we, e.we);
         if (e.we) begin
            chk("pt_waddr", bus.pt_waddr, e.addr);
            chk("pt_wdata", bus.pt_wdata, e.data);
            shadow[e.addr] = e.data;
         end
         chk("done", bus.done, e.done);
         chk("err", bus.err, e.err);
         chk("busy", bus.busy, e.busy);
         chk("cmd_ready", bus.cmd_ready, !e.busy);
`ifdef MMU_PT_READBACK_EN
         if (e.chk_rd) chk("rd_data", bus.rd_data, e.rd);
`endif
         if (bus.pt_we) begin
            n_writes++;
            last_addr = bus.pt_waddr;
            last_data = bus.pt_wdata;
         end
         if (bus.busy) n_busy++;
         if (bus.done) n_done++;
         if (bus.err)  n_err++;
      end
   end

   // Issue one command; with hold, keep garbage on cmd_valid while busy and wait for completion.
   task automatic send(input logic [1:0] op, input logic [11:0] ptb, input logic [4:0] page,
                       input logic [7:0] data, input bit hold);
      int  budget;
      bit  garbage;
      @(negedge clk);
      chk("accept_ready", bus.cmd_ready, 1'b1);
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = op;
      bus.cmd_ptb   = ptb;
      bus.cmd_page  = page;
      bus.cmd_data  = data;
      @(posedge clk);
      model_cmd(op, ptb, page, data);
      #1;
      garbage = !(op == 2'b11 && !RB);
      if (!hold) begin
         bus.cmd_valid = 1'b0;
         return;
      end
      budget = 0;
      while (q.size() > 0 && budget < 6000) begin
         if (garbage) begin
            bus.cmd_valid = 1'b1;
            bus.cmd_op    = 2'($urandom);
            bus.cmd_ptb   = 12'($urandom);
            bus.cmd_page  = 5'($urandom);
            bus.cmd_data  = 8'($urandom);
         end else begin
            bus.cmd_valid = 1'b0;
         end
         @(posedge clk);
         #1;
         budget++;
      end
      bus.cmd_valid = 1'b0;
      chk("cmd_timeout", q.size(), 0);
      q.delete();
   endtask

   initial begin
      int wb, bb, db, eb;
      int budget;
      for (int i = 0; i < 4096; i++) shadow[i] = 8'h00;
      bus.cmd_valid = 1'b0;
      bus.cmd_op    = 2'b00;
      bus.cmd_ptb   = '0;
      bus.cmd_page  = '0;
      bus.cmd_data  = '0;

      // Model pins
      chk("model_wrap", f_addr(12'hFF0, 16), 12'h000);
      chk("model_fill_wrap", f_fill(8'h7E, 2), 8'h80);
      chk("model_fill_first", f_fill(8'h7E, 0), 8'hFE);

      // Reset asserted mid-clock
      #2 rst_n = 1'b0;
      #1;
      chk("rst_ready", bus.cmd_ready, 1'b1);
      chk("rst_busy", bus.busy, 1'b0);
      chk("rst_done", bus.done, 1'b0);
      chk("rst_err", bus.err, 1'b0);
      chk("rst_we", bus.pt_we, 1'b0);
      chk("rst_waddr", bus.pt_waddr, 12'h000);
      chk("rst_wdata", bus.pt_wdata, 8'h00);
`ifdef MMU_PT_READBACK_EN
      chk("rst_raddr", bus.pt_raddr, 12'h000);
      chk("rst_rd_data", bus.rd_data, 8'h00);
`endif
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Single WRITE
      wb = n_writes;
      send(2'b00, 12'h040, 5'd5, 8'h93, 1'b1);
      chk("wr_count", n_writes - wb, 1);
      chk("wr_addr", last_addr, 12'h045);
      chk("wr_data", last_data, 8'h93);

      // op 11: readback or illegal
      wb = n_writes; eb = n_err; db = n_done;
      send(2'b11, 12'h040, 5'd5, 8'h00, 1'b1);
      chk("op11_no_write", n_writes - wb, 0);
`ifdef MMU_PT_READBACK_EN
      chk("read_rd_data", bus.rd_data, 8'h93);
      chk("read_done", n_done - db, 1);
`else
      chk("op11_err", n_err - eb, 1);
      chk("op11_no_done", n_done - db, 0);
`endif

      // FILL across the top of the table
      wb = n_writes; bb = n_busy;
      send(2'b01, 12'hFF0, 5'd0, 8'h7E, 1'b1);
      chk("fill_count", n_writes - wb, 32);
      chk("fill_busy", n_busy - bb, 32);
      chk("fill_last_addr", last_addr, 12'h00F);
      chk("fill_last_data", last_data, 8'h9D);

      // Full CLEAR
      wb = n_writes; bb = n_busy; db = n_done;
      send(2'b10, 12'h000, 5'd0, 8'h00, 1'b1);
      chk("clear_count", n_writes - wb, 4096);
      chk("clear_busy", n_busy - bb, 4096);
      chk("clear_done", n_done - db, 1);
      chk("clear_last_addr", last_addr, 12'hFFF);

      // CLEAR interrupted by reset after about 100 writes
      wb = n_writes;
      send(2'b10, 12'h000, 5'd0, 8'h00, 1'b0);
      budget = 0;
      while (n_writes - wb < 100 && budget < 500) begin
         @(posedge clk);
         #1;
         budget++;
      end
      chk("clear100_reached", (n_writes - wb >= 100), 1'b1);
      #2 rst_n = 1'b0;
      #1;
      q.delete();
      db = n_done;
      chk("midrst_we", bus.pt_we, 1'b0);
      chk("midrst_busy", bus.busy, 1'b0);
      chk("midrst_done", bus.done, 1'b0);
      chk("midrst_ready", bus.cmd_ready, 1'b1);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      chk("midrst_no_done", n_done - db, 0);
      wb = n_writes;
      send(2'b00, 12'h7FF, 5'd31, 8'h5A, 1'b1);
      chk("post_rst_wr_count", n_writes - wb, 1);
      chk("post_rst_wr_addr", last_addr, 12'h81E);
      chk("post_rst_wr_data", last_data, 8'h5A);

      // Randomized commands, biased towards bases near the top of the table
      for (int n = 0; n < 60; n++) begin
         logic [1:0]  op;
         logic [11:0] ptb;
         int          sel;
         sel = int'($urandom_range(0, 9));
         op  = (sel < 4) ? 2'b00 : (sel < 8) ? 2'b01 : (sel == 8) ? 2'b11 : 2'b00;
         ptb = ($urandom_range(0, 1) == 0) ? 12'($urandom_range(4064, 4095)) : 12'($urandom);
         send(op, ptb, 5'($urandom), 8'($urandom), 1'b1);
         repeat ($urandom_range(0, 2)) @(posedge clk);
      end

      repeat (3) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, tests %0d failed %0d", n_tests, n_fail);
      $fatal(1, "watchdog");
   end

endmodule
